// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared states, default image indices and width helper for warm-boot selection
package boot_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_SEL      = 3'd2,
    ST_SEL_WAIT = 3'd3,
    ST_LOCK     = 3'd4,
    ST_BOOT     = 3'd5
  } state_t;

  // SB_WARMBOOT exposes two select pins, so four images at most
  localparam int MAX_IMG     = 4;
  localparam int DEF_IMG_IDX = 2;
  localparam int DFU_IMG_IDX = 1;

  // Width of an image index for a given image count (never below 1 bit)
  function automatic int img_w(input int n_img);
    return (n_img > 2) ? $clog2(n_img) : 1;
  endfunction

endpackage

// File: rtl/boot_timer.sv
// rtl/boot_timer.sv - button-gated timer with tick select plus saturating press counter
module boot_timer #(
  parameter int TICK_B  = 23,
  parameter int REARM_B = 17,
  parameter int LONG_B  = 22
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_v,
  input  logic i_rearm,
  input  logic i_cnt_en,
  output logic o_tick,
  output logic o_long
);

  localparam int TW = ((TICK_B > REARM_B) ? TICK_B : REARM_B) + 1;
  localparam int CW = LONG_B + 1;
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_press_cnt;
  logic          w_tick;

  // The short re-arm bit is used only while the button is disarmed
  assign w_tick = i_rearm ? r_timer[REARM_B] : r_timer[TICK_B];
  assign o_tick = w_tick;
  assign o_long = r_press_cnt[LONG_B];

  // Idle timer restarts on any button activity and on every tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (!i_btn_v || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + T_ONE;
    end
  end

  // Hold-time counter: counts a held button while enabled, saturates, clears on release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press_cnt <= '0;
    end else if (i_btn_v) begin
      r_press_cnt <= '0;
    end else if (i_cnt_en && !(&r_press_cnt)) begin
      r_press_cnt <= r_press_cnt + C_ONE;
    end
  end

endmodule

// File: rtl/boot_selector.sv
// rtl/boot_selector.sv - warm-boot image selection FSM with optional flash-lock handshake
module boot_selector
  import boot_pkg::*;
#(
  parameter int         N_IMG     = 4,
  parameter int         SEL_W     = img_w(MAX_IMG),
  parameter int         DEF_IMG   = DEF_IMG_IDX,
  parameter int         DFU_IMG   = DFU_IMG_IDX,
  parameter logic [3:0] LOCK_MASK = 4'b1110,
  parameter bit         LOCK_EN   = 1'b1,
  parameter int         SEL_TO_B  = 23,
  parameter int         REARM_B   = 17,
  parameter int         LONG_B    = 22
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_v,
  input  logic             i_btn_f,
  input  logic             i_fl_rdy,
  output logic             o_fl_go,
  output logic             o_sel_mode,
  output logic [SEL_W-1:0] o_boot_sel,
  output logic             o_boot_now
);

  if (N_IMG < 2 || N_IMG > MAX_IMG) begin : g_bad_n_img
    $error("boot_selector: N_IMG must be 2..4");
  end
  if (SEL_W < img_w(N_IMG)) begin : g_bad_sel_w
    $error("boot_selector: SEL_W too narrow for N_IMG");
  end
  if (DEF_IMG < 0 || DEF_IMG >= N_IMG) begin : g_bad_def_img
    $error("boot_selector: DEF_IMG out of range");
  end
  if (DFU_IMG < 0 || DFU_IMG >= N_IMG) begin : g_bad_dfu_img
    $error("boot_selector: DFU_IMG out of range");
  end

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IMG - 1);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);
  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEF_IMG);
  localparam logic [SEL_W-1:0] DFU_SEL  = SEL_W'(DFU_IMG);

  state_t           r_state;
  state_t           w_next;
  state_t           w_lock_or_boot;
  logic [SEL_W-1:0] r_boot_sel;
  logic [SEL_W-1:0] w_boot_sel_nxt;
  logic             r_fl_go;
  logic             r_boot_now;
  logic             w_tick;
  logic             w_long;
  logic             w_need_lock;
  logic             w_sel_wait;

  assign w_sel_wait     = (r_state == ST_SEL_WAIT);
  assign w_need_lock    = LOCK_EN && LOCK_MASK[r_boot_sel];
  assign w_lock_or_boot = w_need_lock ? ST_LOCK : ST_BOOT;

  boot_timer #(
    .TICK_B  (SEL_TO_B),
    .REARM_B (REARM_B),
    .LONG_B  (LONG_B)
  ) u_boot_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn_v  (i_btn_v),
    .i_rearm  (w_sel_wait),
    .i_cnt_en (w_sel_wait),
    .o_tick   (w_tick),
    .o_long   (w_long)
  );

  // State, selection and registered handshake/boot outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_START;
      r_boot_sel <= DEF_SEL;
      r_fl_go    <= 1'b0;
      r_boot_now <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_boot_sel <= w_boot_sel_nxt;
      r_fl_go    <= (r_state != ST_LOCK) && (w_next == ST_LOCK);
      r_boot_now <= (r_state == ST_BOOT);
    end
  end

  // Next state and next selection; a press in SEL wins over the timeout
  always_comb begin
    w_next         = r_state;
    w_boot_sel_nxt = r_boot_sel;
    case (r_state)
      ST_START: begin
        w_next = i_btn_v ? w_lock_or_boot : ST_WAIT;
      end
      ST_WAIT: begin
        w_boot_sel_nxt = DFU_SEL;
        if (i_btn_v) begin
          w_next = ST_SEL_WAIT;
        end
      end
      ST_SEL: begin
        if (i_btn_f) begin
          w_next         = ST_SEL_WAIT;
          w_boot_sel_nxt = (r_boot_sel == LAST_SEL) ? '0 : r_boot_sel + ONE_SEL;
        end else if (w_tick) begin
          w_next = w_lock_or_boot;
        end
      end
      ST_SEL_WAIT: begin
        if (w_long) begin
          w_next = w_lock_or_boot;
        end else if (w_tick) begin
          w_next = ST_SEL;
        end
      end
      ST_LOCK: begin
        // fl_rdy still shows the pre-go idle level while fl_go is high
        if (i_fl_rdy && !r_fl_go) begin
          w_next = ST_BOOT;
        end
      end
      ST_BOOT: begin
        w_next = ST_BOOT;
      end
      default: begin
        w_next = ST_START;
      end
    endcase
  end

  assign o_fl_go    = r_fl_go;
  assign o_boot_now = r_boot_now;
  assign o_boot_sel = r_boot_sel;
  assign o_sel_mode = (r_state == ST_WAIT) || (r_state == ST_SEL) || (r_state == ST_SEL_WAIT);

endmodule

// File: tb/tb_boot_selector.sv
// tb/tb_boot_selector.sv - self-checking scoreboard bench for boot_selector
module tb_boot_selector;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       btn_v  = 1'b1;
  logic       btn_f  = 1'b0;
  logic       fl_rdy = 1'b1;
  logic       o_fl_go;
  logic       o_sel_mode;
  logic [1:0] o_boot_sel;
  logic       o_boot_now;

  int cyc     = 0;
  int n_flgo  = 0;
  int fl_cnt  = 0;
  int chk_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int sel;
    int lock;
    int at;
  } boot_exp_t;

  boot_exp_t sb_q[$];

  boot_selector #(
    .N_IMG     (3),
    .SEL_W     (2),
    .DEF_IMG   (2),
    .DFU_IMG   (1),
    .LOCK_MASK (4'b1110),
    .LOCK_EN   (1'b1),
    .SEL_TO_B  (6),
    .REARM_B   (3),
    .LONG_B    (5)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_v    (btn_v),
    .i_btn_f    (btn_f),
    .i_fl_rdy   (fl_rdy),
    .o_fl_go    (o_fl_go),
    .o_sel_mode (o_sel_mode),
    .o_boot_sel (o_boot_sel),
    .o_boot_now (o_boot_now)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // flash_lock stand-in: idle high, drops on fl_go, done 10 clocks later
  always @(negedge clk) begin
    if (!rst_n) begin
      fl_rdy = 1'b1;
      fl_cnt = 0;
    end else if (o_fl_go) begin
      n_flgo = n_flgo + 1;
      fl_rdy = 1'b0;
      fl_cnt = 10;
    end else if (fl_cnt > 0) begin
      fl_cnt = fl_cnt - 1;
      if (fl_cnt == 0) fl_rdy = 1'b1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) nxt();
  endtask

  task automatic do_reset(input logic btn);
    rst_n = 1'b0;
    btn_v = btn;
    btn_f = 1'b0;
    repeat (3) nxt();
    n_flgo = 0;
    rst_n  = 1'b1;
  endtask

  // Reset with the button held, release it in cycle 2; SEL is reached at cycle 11
  task automatic enter_sel();
    do_reset(1'b0);
    nxt();
    nxt();
    btn_v = 1'b1;
  endtask

  task automatic short_press();
    btn_f = 1'b1;
    btn_v = 1'b0;
    nxt();
    btn_f = 1'b0;
    nxt();
    nxt();
    btn_v = 1'b1;
  endtask

  task automatic push_exp(input int sel, input int lock, input int at);
    boot_exp_t e;
    e.sel  = sel;
    e.lock = lock;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_boot(input string tag);
    boot_exp_t e;
    int n;
    n = 0;
    while (!o_boot_now && n < 300) begin
      nxt();
      n++;
    end
    chk({tag, "_boot_seen"}, int'(o_boot_now), 1);
    chk({tag, "_sb_nonempty"}, int'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_sel"}, int'(o_boot_sel), e.sel);
      chk({tag, "_cycle"}, cyc, e.at);
      chk({tag, "_flgo_cnt"}, n_flgo, e.lock);
      chk({tag, "_sel_mode"}, int'(o_sel_mode), 0);
    end
  endtask

  initial begin
    // Reset state, button released
    rst_n = 1'b0;
    repeat (3) nxt();
    chk("rst_fl_go", int'(o_fl_go), 0);
    chk("rst_boot_now", int'(o_boot_now), 0);
    chk("rst_sel_mode", int'(o_sel_mode), 0);
    chk("rst_boot_sel", int'(o_boot_sel), 2);

    // 1: immediate boot of locked default image
    do_reset(1'b1);
    push_exp(2, 1, 13);
    nxt();
    chk("t1_flgo_c1", int'(o_fl_go), 1);
    chk("t1_cyc1", cyc, 1);
    wait_boot("t1");
    btn_f = 1'b1;
    btn_v = 1'b0;
    nxt();
    btn_f = 1'b0;
    btn_v = 1'b1;
    nxt();
    nxt();
    chk("t1_frozen_sel", int'(o_boot_sel), 2);
    chk("t1_boot_hold", int'(o_boot_now), 1);
    chk("t1_no_extra_go", n_flgo, 1);

    // 2: held through reset, released, timeout boots DFU image via lock
    enter_sel();
    wait_until(12);
    chk("t2_sel_mode", int'(o_sel_mode), 1);
    chk("t2_dfu_sel", int'(o_boot_sel), 1);
    push_exp(1, 1, 88);
    wait_boot("t2");

    // 6a: reset asserted while waiting in LOCK
    enter_sel();
    wait_until(80);
    chk("t6a_pre_sel", int'(o_boot_sel), 1);
    chk("t6a_pre_flgo", n_flgo, 1);
    rst_n = 1'b0;
    #1;
    chk("t6a_async_sel", int'(o_boot_sel), 2);
    chk("t6a_async_go", int'(o_fl_go), 0);
    chk("t6a_async_mode", int'(o_sel_mode), 0);
    chk("t6a_async_boot", int'(o_boot_now), 0);
    do_reset(1'b1);
    push_exp(2, 1, 13);
    nxt();
    chk("t6a_restart_go", int'(o_fl_go), 1);
    wait_boot("t6a");

    // 3: three presses wrap 1->2->0->1, then timeout boots image 1
    enter_sel();
    wait_until(15);
    short_press();
    chk("t3_p1", int'(o_boot_sel), 2);
    wait_until(30);
    short_press();
    chk("t3_p2_wrap", int'(o_boot_sel), 0);
    wait_until(45);
    short_press();
    chk("t3_p3", int'(o_boot_sel), 1);
    chk("t3_still_sel", int'(o_sel_mode), 1);
    push_exp(1, 1, 134);
    wait_boot("t3");

    // 6b: reset asserted in BOOT
    nxt();
    nxt();
    rst_n = 1'b0;
    #1;
    chk("t6b_async_boot", int'(o_boot_now), 0);
    chk("t6b_async_sel", int'(o_boot_sel), 2);
    chk("t6b_async_mode", int'(o_sel_mode), 0);

    // 4: advance to image 0, then hold the press until long confirms it
    enter_sel();
    wait_until(15);
    short_press();
    wait_until(30);
    btn_f = 1'b1;
    btn_v = 1'b0;
    push_exp(0, 0, 65);
    nxt();
    btn_f = 1'b0;
    wait_boot("t4");
    btn_v = 1'b1;

    // 5: press lands in the same cycle as the SEL timeout
    enter_sel();
    wait_until(75);
    btn_f = 1'b1;
    btn_v = 1'b0;
    nxt();
    chk("t5_stay_sel", int'(o_sel_mode), 1);
    chk("t5_advance", int'(o_boot_sel), 2);
    chk("t5_no_go", int'(o_fl_go), 0);
    chk("t5_no_boot", int'(o_boot_now), 0);
    btn_f = 1'b0;
    nxt();
    nxt();
    btn_v = 1'b1;
    push_exp(2, 1, 164);
    wait_boot("t5");

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
